// File: rtl/tick_period_meter.sv
// tick_period_meter: counts clk cycles between rising edges of tick_in.
// Optional TICK_SYNC_EN adds a two-flop synchronizer ahead of edge detect.
module tick_period_meter #(
   parameter int CNT_W   = 28,
   parameter int TIMEOUT = 100000000
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             tick_in,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   input  logic             period_ready,
   output logic             timeout,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   typedef enum logic {
      IDLE,
      MEASURE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             timeout_nxt;
   logic             result;
   logic             tick_src;
   logic             tick_s;
   logic             tick_q;
   logic             rise;

`ifdef TICK_SYNC_EN
   logic sync_a;
   logic sync_b;

   always_ff @(posedge clk) begin
      if (Reset) begin
         sync_a <= 1'b1;
         sync_b <= 1'b1;
      end else begin
         sync_a <= tick_in;
         sync_b <= sync_a;
      end
   end

   assign tick_src = sync_b;
`else
   assign tick_src = tick_in;
`endif

   // Both stages reset high so a level already high at release is no edge.
   always_ff @(posedge clk) begin
      if (Reset) begin
         tick_s <= 1'b1;
         tick_q <= 1'b1;
      end else begin
         tick_s <= tick_src;
         tick_q <= tick_s;
      end
   end

   assign rise = tick_s & ~tick_q;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      timeout_nxt = timeout;
      result      = 1'b0;
      unique case (state)
         IDLE: begin
            if (rise) begin
               cnt_nxt     = ONE;
               timeout_nxt = 1'b0;
               state_nxt   = MEASURE;
            end
         end
         MEASURE: begin
            // A rise on the timeout cycle still yields a result.
            if (rise) begin
               result      = 1'b1;
               cnt_nxt     = ONE;
               timeout_nxt = 1'b0;
            end else if (cnt == TO_CNT) begin
               timeout_nxt = 1'b1;
               state_nxt   = IDLE;
            end else begin
               cnt_nxt = cnt + ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state   <= IDLE;
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         timeout <= timeout_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         period       <= '0;
         period_valid <= 1'b0;
         overrun      <= 1'b0;
      end else if (result) begin
         if (!period_valid || period_ready) begin
            period       <= cnt;
            period_valid <= 1'b1;
         end else begin
            overrun <= 1'b1;
         end
      end else if (period_valid && period_ready) begin
         period_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tick_period_meter.sv
// tb_tick_period_meter: random and directed tick trains against an
// edge-time reference model of the period meter.
module tb_tick_period_meter;

   localparam int CNT_W   = 8;
   localparam int TIMEOUT = 64;
`ifdef TICK_SYNC_EN
   localparam int SYNC_D = 2;
`else
   localparam int SYNC_D = 0;
`endif

   logic             clk = 1'b0;
   logic             Reset = 1'b1;
   logic             tick_in = 1'b0;
   logic             period_ready = 1'b1;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             timeout;
   logic             overrun;

   int n_cmp = 0;
   int n_bad = 0;
   bit rnd_rdy = 1'b0;

   always #5 clk = ~clk;

   tick_period_meter #(
      .CNT_W  (CNT_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk         (clk),
      .Reset       (Reset),
      .tick_in     (tick_in),
      .period      (period),
      .period_valid(period_valid),
      .period_ready(period_ready),
      .timeout     (timeout),
      .overrun     (overrun)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp,
                  $time);
      end
   endtask

   // Reference model: rise times and elapsed-cycle arithmetic.
   bit         m_hist[$];
   bit         m_scur, m_sprev, m_armed, m_rise;
   bit         m_valid, m_to, m_ovr, m_din, m_rdy;
   int         cyc = 0;
   int         m_last;
   int         m_res;
   bit         m_res_ok;
   int         m_period;

   task automatic model_reset();
      m_hist.delete();
      repeat (SYNC_D) m_hist.push_back(1'b1);
      m_scur   = 1'b1;
      m_sprev  = 1'b1;
      m_armed  = 1'b0;
      m_valid  = 1'b0;
      m_to     = 1'b0;
      m_ovr    = 1'b0;
      m_period = 0;
      m_last   = 0;
   endtask

   always @(posedge clk) begin
      cyc++;
      m_din = tick_in;
      m_rdy = period_ready;
      if (Reset) begin
         model_reset();
      end else begin
         m_rise   = m_scur & ~m_sprev;
         m_res_ok = 1'b0;
         if (m_rise) begin
            if (m_armed) begin
               m_res    = cyc - m_last;
               m_res_ok = 1'b1;
            end
            m_armed = 1'b1;
            m_last  = cyc;
            m_to    = 1'b0;
         end else if (m_armed && (cyc - m_last) == TIMEOUT) begin
            m_to    = 1'b1;
            m_armed = 1'b0;
         end
         if (m_res_ok) begin
            if (!m_valid || m_rdy) begin
               m_period = m_res;
               m_valid  = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (m_valid && m_rdy) begin
            m_valid = 1'b0;
         end
         m_sprev = m_scur;
         if (SYNC_D == 0) begin
            m_scur = m_din;
         end else begin
            m_scur = m_hist.pop_front();
            m_hist.push_back(m_din);
         end
      end
      #1;
      chk("period", 32'(period), 32'(m_period));
      chk("valid", 32'(period_valid), 32'(m_valid));
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("overrun", 32'(overrun), 32'(m_ovr));
   end

   task automatic step();
      @(negedge clk);
      if (rnd_rdy) period_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic drive(input bit v, input int n);
      repeat (n) begin
         step();
         tick_in = v;
      end
   endtask

   task automatic pulses(input int gap, input int count, input int width);
      repeat (count) begin
         drive(1'b1, width);
         drive(1'b0, gap - width);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      Reset = 1'b0;

      pulses(10, 6, 1);
      drive(1'b0, 4);
      chk("s1_period", 32'(period), 10);
      chk("s1_timeout", 32'(timeout), 0);
      chk("s1_overrun", 32'(overrun), 0);

      drive(1'b1, 1); drive(1'b0, 4);
      drive(1'b1, 1); drive(1'b0, 6);
      drive(1'b1, 1); drive(1'b0, 1);
      drive(1'b1, 1); drive(1'b0, 6);
      chk("s2_gap2", 32'(period), 2);
      drive(1'b1, 1); drive(1'b0, 6);
      drive(1'b1, 3); drive(1'b0, 4);
      drive(1'b1, 1); drive(1'b0, 6);
      chk("s2_level", 32'(period), 7);

      drive(1'b0, 70);
      period_ready = 1'b0;
      pulses(10, 3, 1);
      chk("s3_valid", 32'(period_valid), 1);
      chk("s3_period", 32'(period), 10);
      chk("s3_overrun", 32'(overrun), 1);
      step();
      period_ready = 1'b1;
      step();
      period_ready = 1'b0;
      chk("s3_accept", 32'(period_valid), 0);

      period_ready = 1'b1;
      step();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      drive(1'b1, 1);
      drive(1'b0, 70);
      chk("s4_timeout", 32'(timeout), 1);
      chk("s4_noresult", 32'(period_valid), 0);
      pulses(12, 2, 1);
      drive(1'b0, 4);
      chk("s4_period", 32'(period), 12);
      chk("s4_cleared", 32'(timeout), 0);

      period_ready = 1'b0;
      pulses(9, 3, 1);
      drive(1'b0, 3);
      chk("s5_pre_valid", 32'(period_valid), 1);
      step();
      tick_in = 1'b1;
      Reset   = 1'b1;
      step();
      Reset = 1'b0;
      chk("s5_rst_period", 32'(period), 0);
      chk("s5_rst_valid", 32'(period_valid), 0);
      chk("s5_rst_overrun", 32'(overrun), 0);
      drive(1'b1, 3);
      drive(1'b0, 5);
      chk("s5_no_edge", 32'(period_valid), 0);
      period_ready = 1'b1;
      pulses(9, 4, 1);
      drive(1'b0, 4);
      chk("s5_period", 32'(period), 9);

      rnd_rdy = 1'b1;
      repeat (200) begin
         int g;
         int w;
         g = int'($urandom_range(2, 80));
         w = int'($urandom_range(1, g - 1));
         pulses(g, 1, w);
         if ($urandom_range(0, 40) == 0) begin
            step();
            Reset = 1'b1;
            step();
            Reset = 1'b0;
         end
      end
      rnd_rdy      = 1'b0;
      period_ready = 1'b1;
      drive(1'b0, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
               n_bad);
      $finish;
   end

endmodule

// File: doc/tick_period_meter.md
# tick_period_meter

Measures the number of `clk` cycles between consecutive rising edges of a tick input. The usual source is the one-cycle terminal-count pulse of our clock divider. Each completed measurement is delivered on a valid/ready output port. A timeout flag reports that ticks have stopped. The block is the consuming end of the divider tick: it is used for self-check of divider ratios and for measuring external pulse trains.

## Interface
- `CNT_W`, default 28: width of the period counter and of the result.
- `TIMEOUT`, default 100000000: number of counted cycles without a rising edge that aborts a measurement. Must satisfy 2 ≤ `TIMEOUT` ≤ 2^`CNT_W`−1.
- `clk`  in  1: single clock; every register is on its rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `tick_in`  in  1: pulse or level train being measured.
- `period`  out  `CNT_W`: measured cycles between two rising edges; held while `period_valid` is high.
- `period_valid`  out  1: result available.
- `period_ready`  in  1: consumer accepts the result when `period_valid && period_ready`.
- `timeout`  out  1: sticky; ticks stopped.
- `overrun`  out  1: sticky; a result was dropped because the previous one was not accepted.

## Operation
- Edge detect: `tick_q <= tick_s` each cycle. `rise = tick_s & ~tick_q`.
  - `tick_s` is `tick_in`, or the synchronizer output (see Configuration).
  - A level held high for several cycles produces one rise.
- States:
  - `IDLE`: waiting for the first edge. On `rise`: `cnt <= 1`, go to `MEASURE`.
  - `MEASURE`, no `rise`, `cnt != TIMEOUT`: `cnt <= cnt+1`.
  - `MEASURE`, `rise`: produce result `cnt`, `cnt <= 1`, stay in `MEASURE`.
  - `MEASURE`, no `rise`, `cnt == TIMEOUT`: `timeout <= 1`, go to `IDLE`, no result produced.
- Rising edges at cycles t0 and t0+N give `period = N`. Minimum measurable N is 2.
- `timeout` clears on the next `rise`. Reaching `TIMEOUT` and a `rise` in the same cycle: the rise wins, a result is produced and `timeout` stays 0.
- The counter never wraps, because the `TIMEOUT` bound keeps it in range.
- Output register (one-entry buffer), on a new result:
  - If `!period_valid`, or if `period_ready` is high the same cycle: load `period`, `period_valid <= 1`.
  - Otherwise: keep the old `period`, drop the new one, set `overrun <= 1`.
- Without a new result: `period_valid <= 0` on accept.
- `overrun` clears only on `Reset`.

## Timing
- Reset values: `period = 0`, `period_valid = 0`, `timeout = 0`, `overrun = 0`, state `IDLE`, `cnt = 0`, `tick_q = 1`.
  - Because `tick_q` resets to 1, `tick_in` already high at reset release is not an edge.
- `Reset` asserted mid-measurement discards the partial count and any unaccepted result. It takes effect at the next `clk` edge and has priority over all other events.
- Latency without synchronizer: `tick_in` sampled high at clock edge k (low at k−1) gives `period`/`period_valid` updated at edge k+1.
- `period` is stable and `period_valid` stays high until accepted. No combinational path from `period_ready` to any output.
- `timeout` asserts at the edge where `cnt == TIMEOUT` is evaluated, i.e. `TIMEOUT+1` edges after the last rise was sampled.

## Configuration
- `TICK_SYNC_EN` defined: `tick_in` passes through a two-flop synchronizer (both flops reset to 1) before edge detection.
  - Safe for asynchronous inputs.
  - Adds 2 cycles of latency.
  - Measured periods are unchanged.
- `TICK_SYNC_EN` undefined: `tick_in` is used directly and must be synchronous to `clk`. No added latency.

## Test plan
Bench parameters: `CNT_W = 8`, `TIMEOUT = 64`.
- One-cycle pulses every 10 cycles, `period_ready = 1` → `period_valid` pulses once per tick from the second tick on, `period = 10`. `timeout = 0`, `overrun = 0`.
- Pulses at periods 5, 7, 2 with `period_ready = 1` → results 5, 7, 2 in order. A level held high 3 cycles inside a period-7 train is counted as one edge.
- `period_ready = 0`, pulses every 10 → first result 10 held stable. At the next tick `overrun = 1` and `period` is still 10. Raising `period_ready` gives one accept, then `period_valid = 0`.
- Single pulse, then `tick_in = 0` for 70 cycles → `timeout = 1` exactly 65 edges after the pulse was sampled, no result. The next two pulses 12 apart clear `timeout` and give `period = 12`.
- `Reset` asserted for 1 cycle mid-period with `period_valid = 1` → all outputs 0 on the next edge. `tick_in` held high across reset release produces no edge. Subsequent pulses every 9 give `period = 9`.
- With `TICK_SYNC_EN`, repeat the 10-cycle scenario → same values, every `period_valid` 2 cycles later.
